// File: rtl/elevador_pkg.sv
// Shared definitions for the elevator control unit: queue sizing and the
// 4-bit state codes shown on the debug display.
package elevador_pkg;

  localparam int PROFUNDIDADE = 16;
  localparam int LARG_CONT    = 5;

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    OCIOSO     = 4'h1,
    GRAVA_ORIG = 4'h2,
    GRAVA_DEST = 4'h3,
    DECIDE     = 4'h4,
    ESPERA     = 4'h5,
    ANDA       = 4'h6,
    PORTA      = 4'h7,
    REMOVE     = 4'h8
  } estado_t;

endpackage

// File: rtl/uc_elevador_contador_fila.sv
// Saturating up/down counter tracking how many stops sit in the FD queue.
// fila_cheia flags that a full origin/destination pair no longer fits.
module contador_fila #(
  parameter int PROFUNDIDADE = 16,
  parameter int LARG_CONT    = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  input  logic                 dec,
  output logic [LARG_CONT-1:0] occ,
  output logic                 fila_cheia
);

  localparam logic [LARG_CONT-1:0] MAXIMO = LARG_CONT'(PROFUNDIDADE);
  localparam logic [LARG_CONT-1:0] LIMIAR = LARG_CONT'(PROFUNDIDADE - 2);

  // Occupancy register: clamps at 0 and at the queue depth
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      occ <= '0;
    end else if (inc && !dec && (occ != MAXIMO)) begin
      occ <= occ + 1'b1;
    end else if (dec && !inc && (occ != '0)) begin
      occ <= occ - 1'b1;
    end
  end

  assign fila_cheia = (occ > LIMIAR);

endmodule

// File: rtl/uc_elevador.sv
// Elevator control unit: Moore FSM that serialises requests into the FD stop
// queue, steps the car one floor per timer period and opens the door at stops.
//
// Request handshake: bordaNovaEntrada is a single-cycle pulse with no ready
// back-pressure. It is latched into pend in every state except INICIAL unless
// the queue is full, in which case it is dropped and rejeitado pulses on the
// following cycle. A pulse that arrives while pend is already set is lost, so
// the requester must hold origem/destino stable until GRAVA_DEST completes.
module uc_elevador #(
  parameter int PROFUNDIDADE = elevador_pkg::PROFUNDIDADE,
  parameter int LARG_CONT    = elevador_pkg::LARG_CONT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bordaNovaEntrada,
  input  logic       chegouDestino,
  input  logic       fimT,
  input  logic [3:0] proxParada,
  input  logic [3:0] andarAtual,
  output logic       enableRAM,
  output logic       enableTopRAM,
  output logic       shift,
  output logic       select1,
  output logic       select2,
  output logic       zeraT,
  output logic       contaT,
  output logic       clearAndarAtual,
  output logic       clearSuperRam,
  output logic       enableAndarAtual,
  output logic       filaCheia,
  output logic       rejeitado,
  output logic [3:0] db_estado
);

  import elevador_pkg::*;

  estado_t              estado, prox_estado;
  logic                 pend, pend_n;
  logic                 dir, dir_n;
  logic                 rej;
  logic                 aceita;
  logic                 inc, dec, clr;
  logic                 fila_cheia;
  logic [LARG_CONT-1:0] occ;

  contador_fila #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARG_CONT    (LARG_CONT)
  ) u_contador (
    .clock      (clock),
    .reset      (reset),
    .clear      (clr),
    .inc        (inc),
    .dec        (dec),
    .occ        (occ),
    .fila_cheia (fila_cheia)
  );

  assign aceita = bordaNovaEntrada && (estado != INICIAL) && !fila_cheia;
  assign inc    = (estado == GRAVA_ORIG) || (estado == GRAVA_DEST);
  assign dec    = (estado == REMOVE);
  assign clr    = (estado == INICIAL);

  // State, pending-request latch, travel direction and reject pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= INICIAL;
      pend   <= 1'b0;
      dir    <= 1'b0;
      rej    <= 1'b0;
    end else begin
      estado <= prox_estado;
      pend   <= pend_n;
      dir    <= dir_n;
      rej    <= bordaNovaEntrada && (estado != INICIAL) && fila_cheia;
    end
  end

  // Next-state selection and Moore decode of every FD control line
  always_comb begin
    prox_estado      = estado;
    pend_n           = pend;
    dir_n            = dir;
    enableRAM        = 1'b0;
    enableTopRAM     = 1'b0;
    shift            = 1'b0;
    select1          = 1'b0;
    select2          = 1'b0;
    zeraT            = 1'b0;
    contaT           = 1'b0;
    clearAndarAtual  = 1'b0;
    clearSuperRam    = 1'b0;
    enableAndarAtual = 1'b0;
    case (estado)
      INICIAL: begin
        clearAndarAtual = 1'b1;
        clearSuperRam   = 1'b1;
        zeraT           = 1'b1;
        prox_estado     = OCIOSO;
      end
      OCIOSO: begin
        if (pend || bordaNovaEntrada) prox_estado = GRAVA_ORIG;
      end
      GRAVA_ORIG: begin
        select1     = 1'b1;
        enableRAM   = 1'b1;
        prox_estado = GRAVA_DEST;
      end
      GRAVA_DEST: begin
        enableRAM   = 1'b1;
        pend_n      = 1'b0;
        prox_estado = DECIDE;
      end
      DECIDE: begin
        // Timer restarts here so ESPERA/PORTA always see a full period
        zeraT = 1'b1;
        if (pend && !fila_cheia) begin
          prox_estado = GRAVA_ORIG;
        end else if (occ == '0) begin
          prox_estado = OCIOSO;
        end else if (chegouDestino) begin
          prox_estado = PORTA;
        end else begin
          dir_n       = (proxParada > andarAtual);
          prox_estado = ESPERA;
        end
      end
      ESPERA: begin
        contaT = 1'b1;
        if (fimT) prox_estado = ANDA;
      end
      ANDA: begin
        enableAndarAtual = 1'b1;
        select2          = dir;
        zeraT            = 1'b1;
        prox_estado      = DECIDE;
      end
      PORTA: begin
        contaT = 1'b1;
        if (fimT) prox_estado = REMOVE;
      end
      REMOVE: begin
        shift       = 1'b1;
        zeraT       = 1'b1;
        prox_estado = DECIDE;
      end
      default: prox_estado = INICIAL;
    endcase
    // A new request outranks the clear in GRAVA_DEST so back-to-back pulses survive
    if (aceita) pend_n = 1'b1;
  end

  assign filaCheia = fila_cheia;
  assign rejeitado = rej;
  assign db_estado = estado;

  // Popping an empty queue would desynchronise occ from the FD RAM
  a_remove_nao_vazio: assert property (@(posedge clock) disable iff (reset)
    (estado == REMOVE) |-> (occ != '0));

endmodule
